// File: rtl/reset_seq_pkg.sv
// Shared types for the HDMI command encoder reset sequencer.
package reset_seq_pkg;

  // Sequencer phases: waiting for lock, stepping through releases, all released.
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } seq_state_t;

endpackage

// File: rtl/reset_sequencer_sync_bit.sv
// Single-bit synchronizer: a chain of STAGES flops that clear asynchronously.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the chain; clear the whole chain on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_DOMAINS active-low resets in index order, HOLD_CYCLES apart,
// once the clocking resource reports lock; lock loss or a software request
// re-asserts every domain and restarts the sequence.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   resetn_async,
  input  logic                   locked,
  input  logic                   sw_reset_req,
  output logic [NUM_DOMAINS-1:0] domain_resetn,
  output logic                   ready,
  output logic                   lock_lost
);

  localparam int CNT_W = $clog2(HOLD_CYCLES);
  localparam int IDX_W = $clog2(NUM_DOMAINS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] DOM_ONE = NUM_DOMAINS'(1);

  logic [1:0]             rst_sync_q;
  logic                   rst_n;
  logic                   locked_s;
  logic                   abort;
  seq_state_t             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [IDX_W-1:0]       idx_q;
  logic [NUM_DOMAINS-1:0] domain_resetn_q;
  logic                   ready_q;
  logic                   lock_lost_q;

  // Internal reset: asserts immediately with resetn_async, releases two edges later.
  always_ff @(posedge clk or negedge resetn_async) begin
    if (!resetn_async) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_locked_sync (
    .clk_i (clk),
    .rst_ni(rst_n),
    .d_i   (locked),
    .q_o   (locked_s)
  );

  // Lock loss and software request both restart the sequence from scratch.
  assign abort = !locked_s || sw_reset_req;

  // Sequencer FSM: hold counter, domain index, per-domain resets and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= WAIT_LOCK;
      cnt_q           <= '0;
      idx_q           <= '0;
      domain_resetn_q <= '0;
      ready_q         <= 1'b0;
      lock_lost_q     <= 1'b0;
    end else begin
      // A lock drop seen in RUN outranks a same-edge software clear.
      if (state_q == RUN && !locked_s) begin
        lock_lost_q <= 1'b1;
      end else if (sw_reset_req) begin
        lock_lost_q <= 1'b0;
      end

      case (state_q)
        WAIT_LOCK: begin
          domain_resetn_q <= '0;
          ready_q         <= 1'b0;
          cnt_q           <= '0;
          idx_q           <= '0;
          if (locked_s) begin
            state_q <= HOLD;
          end
        end

        HOLD: begin
          if (abort) begin
            domain_resetn_q <= '0;
            ready_q         <= 1'b0;
            cnt_q           <= '0;
            idx_q           <= '0;
            state_q         <= WAIT_LOCK;
          end else if (cnt_q == CNT_LAST) begin
            domain_resetn_q <= domain_resetn_q | (DOM_ONE << idx_q);
            cnt_q           <= '0;
            if (idx_q == IDX_LAST) begin
              state_q <= RUN;
              ready_q <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        RUN: begin
          if (abort) begin
            domain_resetn_q <= '0;
            ready_q         <= 1'b0;
            cnt_q           <= '0;
            idx_q           <= '0;
            state_q         <= WAIT_LOCK;
          end else begin
            domain_resetn_q <= '1;
            ready_q         <= 1'b1;
          end
        end

        default: begin
          domain_resetn_q <= '0;
          ready_q         <= 1'b0;
          cnt_q           <= '0;
          idx_q           <= '0;
          state_q         <= WAIT_LOCK;
        end
      endcase
    end
  end

  assign domain_resetn = domain_resetn_q;
  assign ready         = ready_q;
  assign lock_lost     = lock_lost_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized scoreboard bench for reset_sequencer. The reference model tracks
// time spent sequencing and derives the released-domain count arithmetically.
module tb_reset_sequencer;

  localparam int N = 3;
  localparam int H = 4;
  localparam int S = 2;
  localparam int NCYC = 4000;

  logic         clk;
  logic         resetn_async;
  logic         locked;
  logic         sw_reset_req;
  logic [N-1:0] domain_resetn;
  logic         ready;
  logic         lock_lost;

  reset_sequencer #(
    .NUM_DOMAINS(N),
    .HOLD_CYCLES(H),
    .SYNC_STAGES(S)
  ) dut (
    .clk          (clk),
    .resetn_async (resetn_async),
    .locked       (locked),
    .sw_reset_req (sw_reset_req),
    .domain_resetn(domain_resetn),
    .ready        (ready),
    .lock_lost    (lock_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] dom;
    logic         rdy;
    logic         ll;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle_no = 0;
  bit   dut_ready_seen = 0;
  bit   dut_lost_seen = 0;

  // Reference model state
  int   m_rst_cnt;   // edges since resetn_async released (saturates at 2)
  bit   m_hist[$];   // locked samples, newest first
  bit   m_locked_s;
  bit   m_waiting;   // true while no sequence is in progress
  int   m_t;         // edges elapsed since entering the sequence (saturates)
  bit   m_lock_lost;

  function automatic void model_clear();
    m_rst_cnt   = 0;
    m_hist.delete();
    m_locked_s  = 0;
    m_waiting   = 1;
    m_t         = 0;
    m_lock_lost = 0;
  endfunction

  function automatic void model_edge();
    bit rst_pre;
    bit ls;
    bit in_run;
    if (!resetn_async) begin
      model_clear();
      return;
    end
    rst_pre = (m_rst_cnt >= 2);
    if (rst_pre) begin
      ls     = m_locked_s;
      in_run = !m_waiting && (m_t >= N * H);
      if (in_run && !ls) m_lock_lost = 1;
      else if (sw_reset_req) m_lock_lost = 0;
      if (m_waiting) begin
        if (ls) begin
          m_waiting = 0;
          m_t       = 0;
        end
      end else if (!ls || sw_reset_req) begin
        m_waiting = 1;
        m_t       = 0;
      end else if (m_t < N * H) begin
        m_t++;
      end
      m_hist.push_front(locked);
      if (m_hist.size() > S) void'(m_hist.pop_back());
      m_locked_s = (m_hist.size() >= S) ? m_hist[S-1] : 1'b0;
    end
    if (m_rst_cnt < 2) m_rst_cnt++;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int   released;
    released = m_waiting ? 0 : (m_t / H);
    if (released > N) released = N;
    e.dom = N'((1 << released) - 1);
    e.rdy = (released == N);
    e.ll  = m_lock_lost;
    return e;
  endfunction

  // Monitor: compare DUT outputs against the oldest expectation, mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (domain_resetn !== e.dom) begin
        errors++;
        $display("FAIL domain_resetn cycle %0d: got %b expected %b", cycle_no, domain_resetn, e.dom);
      end
      checks++;
      if (ready !== e.rdy) begin
        errors++;
        $display("FAIL ready cycle %0d: got %b expected %b", cycle_no, ready, e.rdy);
      end
      checks++;
      if (lock_lost !== e.ll) begin
        errors++;
        $display("FAIL lock_lost cycle %0d: got %b expected %b", cycle_no, lock_lost, e.ll);
      end
      if (ready === 1'b1) dut_ready_seen = 1;
      if (lock_lost === 1'b1) dut_lost_seen = 1;
    end
  end

  // Stimulus: random lock drops, software requests and async resets.
  initial begin
    int rst_hold;
    resetn_async = 1'b0;
    locked       = 1'b1;
    sw_reset_req = 1'b0;
    rst_hold     = 3;
    model_clear();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      model_edge();
      #1;
      cycle_no = cyc;
      if (rst_hold > 0) begin
        rst_hold--;
        resetn_async = 1'b0;
      end else if (resetn_async && $urandom_range(0, 299) == 0) begin
        rst_hold     = $urandom_range(0, 2);
        resetn_async = 1'b0;
      end else begin
        resetn_async = 1'b1;
      end
      if (locked) begin
        if ($urandom_range(0, 59) == 0) locked = 1'b0;
      end else begin
        if ($urandom_range(0, 7) == 0) locked = 1'b1;
      end
      sw_reset_req = ($urandom_range(0, 49) == 0);
      if (!resetn_async) model_clear();
      exp_q.push_back(model_out());
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    checks++;
    if (!dut_ready_seen) begin
      errors++;
      $display("FAIL ready_reached: got ready never high expected at least once");
    end
    checks++;
    if (!dut_lost_seen) begin
      errors++;
      $display("FAIL lock_lost_reached: got lock_lost never high expected at least once");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
